// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with shadowed divisors, global phase sync and
// write validation. Latency: outputs are registered with each counter. cfg_err is one cycle after the strobe.
module clk_div_gen #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic wr_ok;
  assign wr_ok = cfg_wr && (32'(cfg_ch) < NUM_CH) && (cfg_div >= DIV_W'(2));

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !wr_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt, n_act, n_shd;
    logic [DIV_W-1:0] cnt_nxt, n_nxt, s_nxt;
    logic             wr_hit, wrap, clk_r, tick_r;

    // A write forwards straight into N whenever N reloads on the same edge.
    // Reload happens on wrap, on sync, or on every disabled cycle.
    always_comb begin
      wr_hit  = wr_ok && (cfg_ch == 3'(g));
      s_nxt   = wr_hit ? cfg_div : n_shd;
      wrap    = (cnt == n_act - ONE);
      cnt_nxt = '0;
      n_nxt   = s_nxt;
      if (ch_en[g] && !sync && !wrap) begin
        cnt_nxt = cnt + ONE;
        n_nxt   = n_act;
      end
    end

    // Outputs are computed from next-state values so they stay aligned with cnt.
    always_ff @(posedge clk_50m) begin
      if (rst) begin
        cnt    <= '0;
        n_act  <= DEF_N;
        n_shd  <= DEF_N;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        n_act  <= n_nxt;
        n_shd  <= s_nxt;
        clk_r  <= ch_en[g] && (cnt_nxt >= (n_nxt >> 1));
        tick_r <= ch_en[g] && (cnt_nxt == n_nxt - ONE);
      end
    end

    assign clk_out[g] = clk_r;
    assign tick[g]    = tick_r;
  end

endmodule
